// File: rtl/systolic_pkg.sv
// Shared state encoding and default sizing for the systolic skew feeder.
package systolic_pkg;

   localparam int unsigned DEF_N       = 16;
   localparam int unsigned DEF_DW      = 8;
   localparam int unsigned FEED_CYCLES = 2 * DEF_N - 1;
   localparam int unsigned CNT_W       = $clog2(2 * DEF_N);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      CLEAR = 3'd2,
      FEED  = 3'd3,
      DONE  = 3'd4
   } feeder_state_t;

   // Number of feed_valid cycles for an n-lane array.
   function automatic int unsigned feed_cycles(input int unsigned n);
      return 2 * n - 1;
   endfunction

   // Counter width that holds every feed index 0..2n-2 plus the one-ahead injection index.
   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(2 * n);
   endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage register chain for one operand lane; DEPTH=0 degenerates to a wire.
module skew_delay_line #(
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] din,
   output logic [DW-1:0] dout
);

   if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;
      assign dout           = din;
   end else begin : g_chain
      logic [DW-1:0] stage_q [DEPTH];

      for (genvar s = 0; s < DEPTH; s++) begin : g_stage
         logic [DW-1:0] prev_c;

         if (s == 0) begin : g_head
            assign prev_c = din;
         end else begin : g_body
            assign prev_c = stage_q[s-1];
         end

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               stage_q[s] <= '0;
            end else begin
               stage_q[s] <= prev_c;
            end
         end
      end

      assign dout = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/systolic_skew_feeder.sv
// Buffers one N-beat A/B operand tile and replays it diagonally skewed into the PE array,
// bracketing each tile with a pe_clear pulse before and a done pulse after the feed.
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int unsigned num_of_columns = DEF_N,
   parameter int unsigned data_width     = DEF_DW
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 load_valid,
   output logic                                 load_ready,
   input  logic [num_of_columns*data_width-1:0] load_a,
   input  logic [num_of_columns*data_width-1:0] load_b,
   input  logic                                 start,
   output logic                                 busy,
   output logic                                 pe_clear,
   output logic                                 feed_valid,
   output logic [num_of_columns*data_width-1:0] feed_left_tot,
   output logic [num_of_columns*data_width-1:0] feed_up_tot,
   output logic                                 done
);

   localparam int unsigned N      = num_of_columns;
   localparam int unsigned DW     = data_width;
   localparam int unsigned BUS_W  = N * DW;
   localparam int unsigned LAST_T = feed_cycles(N) - 1;
   localparam int unsigned FC_W   = cnt_width(N);
   localparam int unsigned IDX_W  = $clog2(N);

   feeder_state_t    state_q, state_nx;
   logic [IDX_W-1:0] beat_cnt_q;
   logic [FC_W-1:0]  feed_cnt_q;
   logic [BUS_W-1:0] buf_a_q [N];
   logic [BUS_W-1:0] buf_b_q [N];

   logic             accept_c;
   logic             feed_on_c;
   logic             inj_live_c;
   logic [FC_W-1:0]  inj_idx_c;
   logic [BUS_W-1:0] inj_a_c, inj_b_c;
   logic [BUS_W-1:0] skew_a_c, skew_b_c;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nx;
      end
   end

   // Next-state logic; a beat is accepted only while IDLE.
   always_comb begin
      state_nx = state_q;
      accept_c = 1'b0;
      case (state_q)
         IDLE: begin
            accept_c = load_valid;
            if (load_valid && (beat_cnt_q == IDX_W'(N - 1))) begin
               state_nx = ARMED;
            end
         end
         ARMED: begin
            if (start) begin
               state_nx = CLEAR;
            end
         end
         CLEAR: state_nx = FEED;
         FEED: begin
            if (feed_cnt_q == FC_W'(LAST_T)) begin
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Beat counter and feed counter; the feed counter tracks the visible feed index t.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         beat_cnt_q <= '0;
         feed_cnt_q <= '0;
      end else begin
         if (accept_c) begin
            beat_cnt_q <= (beat_cnt_q == IDX_W'(N - 1)) ? '0 : beat_cnt_q + IDX_W'(1);
         end
         if ((state_q == FEED) && (state_nx == FEED)) begin
            feed_cnt_q <= feed_cnt_q + FC_W'(1);
         end else begin
            feed_cnt_q <= '0;
         end
      end
   end

   // Tile buffer, one slot per beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned e = 0; e < N; e++) begin
            buf_a_q[e] <= '0;
            buf_b_q[e] <= '0;
         end
      end else if (accept_c) begin
         buf_a_q[beat_cnt_q] <= load_a;
         buf_b_q[beat_cnt_q] <= load_b;
      end
   end

   // Injection runs one cycle ahead of the output register: beat 0 enters during CLEAR,
   // beat t+1 during feed cycle t, zeros once the tile is exhausted so the lines drain.
   always_comb begin
      inj_idx_c  = (state_q == FEED) ? feed_cnt_q + FC_W'(1) : '0;
      inj_live_c = (state_q == CLEAR) || ((state_q == FEED) && (inj_idx_c < FC_W'(N)));
      inj_a_c    = '0;
      inj_b_c    = '0;
      if (inj_live_c) begin
         inj_a_c = buf_a_q[inj_idx_c[IDX_W-1:0]];
         inj_b_c = buf_b_q[inj_idx_c[IDX_W-1:0]];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_lane
      skew_delay_line #(
         .DW    (DW),
         .DEPTH (i)
      ) u_skew_a (
         .clk  (clk),
         .rst  (rst),
         .din  (inj_a_c[i*DW +: DW]),
         .dout (skew_a_c[i*DW +: DW])
      );

      skew_delay_line #(
         .DW    (DW),
         .DEPTH (i)
      ) u_skew_b (
         .clk  (clk),
         .rst  (rst),
         .din  (inj_b_c[i*DW +: DW]),
         .dout (skew_b_c[i*DW +: DW])
      );
   end

   assign feed_on_c = (state_nx == FEED);

   // Registered outputs decoded from the upcoming state; data buses are forced to 0 when not feeding.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         load_ready    <= 1'b1;
         busy          <= 1'b0;
         pe_clear      <= 1'b0;
         feed_valid    <= 1'b0;
         feed_left_tot <= '0;
         feed_up_tot   <= '0;
         done          <= 1'b0;
      end else begin
         load_ready    <= (state_nx == IDLE);
         busy          <= (state_nx != IDLE);
         pe_clear      <= (state_nx == CLEAR);
         feed_valid    <= feed_on_c;
         feed_left_tot <= feed_on_c ? skew_a_c : '0;
         feed_up_tot   <= feed_on_c ? skew_b_c : '0;
         done          <= (state_nx == DONE);
      end
   end

endmodule
